arb_word_packer: RTL and testbench



---
 rtl/arb_word_packer_pkg.sv | 28 ++
 rtl/arb_word_packer_lane.sv | 39 +++
 rtl/arb_word_packer.sv | 160 ++++++++++++++++
 tb/tb_arb_word_packer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arb_word_packer_pkg.sv
// Shared constants and types for the arbiter word packer.
//   NUM_CH  number of arbiter source channels (power of two)
//   DW      byte width delivered by the arbiter
//   BPW     bytes packed into each output word
//   state_t flush sequencer states
//   CH_A..CH_D channel indices as seen on out_ch
package arb_word_packer_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned DW     = 8;
    localparam int unsigned BPW    = 4;

    localparam int unsigned WW  = DW * BPW;          // packed word width
    localparam int unsigned CHW = $clog2(NUM_CH);    // channel index width
    localparam int unsigned CW  = $clog2(BPW);       // stored lane count width (0..BPW-1)
    localparam int unsigned OCW = $clog2(BPW + 1);   // emitted byte count width (1..BPW)

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [CHW-1:0] CH_A = CHW'(0);
    localparam logic [CHW-1:0] CH_B = CHW'(1);
    localparam logic [CHW-1:0] CH_C = CHW'(2);
    localparam logic [CHW-1:0] CH_D = CHW'(3);

endpackage

// File: rtl/arb_word_packer_lane.sv
// Per-channel holding register for the word packer.
//   clk, rst_n  clock and synchronous active-low reset
//   din         byte to store in the next free lane
//   we          store din and advance the lane count
//   clr         discard the held bytes (takes priority over we)
//   word        held bytes, first byte in the low lane, unused lanes zero
//   cnt         number of bytes currently held (0..BPW-1)
//   full        the next write completes a word
module arb_lane_accum
    import arb_word_packer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] din,
    input  logic          we,
    input  logic          clr,
    output logic [WW-1:0] word,
    output logic [CW-1:0] cnt,
    output logic          full
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (clr) begin
            // A byte written together with clr has already been emitted by
            // the parent from the combinational merge, so it is dropped here.
            word <= '0;
            cnt  <= '0;
        end else if (we) begin
            word[cnt*DW +: DW] <= din;
            cnt                <= cnt + CW'(1);
        end
    end

    assign full = (cnt == CW'(BPW - 1));

endmodule

// File: rtl/arb_word_packer.sv
// Packs the round-robin arbiter's serial byte stream into per-channel words.
//   clk, rst_n  clock and synchronous active-low reset
//   din         byte from the arbiter, accepted while din_valid is high
//   din_valid   arbiter valid
//   flush       single-cycle request to drain all partial words
//   out_word    packed word, first-received byte in the low lane, unused lanes 0
//   out_ch      source channel of out_word
//   out_cnt     number of valid bytes in out_word (1..BPW)
//   out_valid   one-cycle pulse qualifying out_word/out_ch/out_cnt
//   busy        high while the flush sequence runs
//   flush_done  one-cycle pulse in the last cycle of the flush sequence
module arb_word_packer
    import arb_word_packer_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [DW-1:0]  din,
    input  logic           din_valid,
    input  logic           flush,
    output logic [WW-1:0]  out_word,
    output logic [CHW-1:0] out_ch,
    output logic [OCW-1:0] out_cnt,
    output logic           out_valid,
    output logic           busy,
    output logic           flush_done
);

    logic [CHW-1:0] gnt;
    logic [CHW-1:0] byte_ch;
    state_t         state, state_nx;
    logic [CHW-1:0] fptr, fptr_nx;

    logic [WW-1:0]     lane_word [NUM_CH];
    logic [CW-1:0]     lane_cnt  [NUM_CH];
    logic [NUM_CH-1:0] lane_full;
    logic [NUM_CH-1:0] lane_we;
    logic [NUM_CH-1:0] lane_clr;

    logic [WW-1:0]  merged_word;
    logic           word_hit;
    logic           emit;
    logic [CHW-1:0] emit_ch;
    logic [WW-1:0]  emit_word;
    logic [OCW-1:0] emit_cnt;
    logic           flush_end;

    // Mirror of the arbiter grant; the byte seen now was granted one slot ago.
    always_ff @(posedge clk) begin
        if (!rst_n) gnt <= '0;
        else        gnt <= gnt + CHW'(1);
    end

    assign byte_ch = gnt - CHW'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        arb_lane_accum u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .din   (din),
            .we    (lane_we[i]),
            .clr   (lane_clr[i]),
            .word  (lane_word[i]),
            .cnt   (lane_cnt[i]),
            .full  (lane_full[i])
        );
    end

    // Held bytes of the incoming byte's channel with the new byte appended.
    assign merged_word = lane_word[byte_ch] | (WW'(din) << (DW * lane_cnt[byte_ch]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            fptr  <= CH_A;
        end else begin
            state <= state_nx;
            fptr  <= fptr_nx;
        end
    end

    always_comb begin
        lane_we   = '0;
        lane_clr  = '0;
        emit      = 1'b0;
        emit_ch   = '0;
        emit_word = '0;
        emit_cnt  = '0;
        state_nx  = state;
        fptr_nx   = fptr;
        flush_end = 1'b0;

        if (din_valid) lane_we[byte_ch] = 1'b1;

        // A completed word takes the output slot, except on the channel being
        // flushed this cycle, where the flush emit already carries the byte.
        word_hit = din_valid && lane_full[byte_ch] &&
                   !(state == FLUSH && byte_ch == fptr);

        if (word_hit) begin
            emit              = 1'b1;
            emit_ch           = byte_ch;
            emit_word         = merged_word;
            emit_cnt          = OCW'(BPW);
            lane_clr[byte_ch] = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (flush) begin
                    state_nx = FLUSH;
                    fptr_nx  = CH_A;
                end
            end
            FLUSH: begin
                // fptr holds still on a cycle lost to a completed word
                if (!word_hit) begin
                    if (din_valid && byte_ch == fptr) begin
                        emit      = 1'b1;
                        emit_ch   = fptr;
                        emit_word = merged_word;
                        emit_cnt  = OCW'(lane_cnt[fptr]) + OCW'(1);
                    end else if (lane_cnt[fptr] != '0) begin
                        emit      = 1'b1;
                        emit_ch   = fptr;
                        emit_word = lane_word[fptr];
                        emit_cnt  = OCW'(lane_cnt[fptr]);
                    end
                    lane_clr[fptr] = 1'b1;
                    if (fptr == CH_D) begin
                        state_nx  = IDLE;
                        flush_end = 1'b1;
                    end else begin
                        fptr_nx = fptr + CHW'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_word  <= '0;
            out_ch    <= '0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= emit;
            if (emit) begin
                out_word <= emit_word;
                out_ch   <= emit_ch;
                out_cnt  <= emit_cnt;
            end
        end
    end

    assign busy       = (state == FLUSH);
    assign flush_done = flush_end & rst_n;

endmodule

// File: tb/tb_arb_word_packer.sv
module tb_arb_word_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] out_word;
    logic [1:0]  out_ch;
    logic [2:0]  out_cnt;
    logic        out_valid;
    logic        busy;
    logic        flush_done;

    int checks = 0;
    int errors = 0;

    arb_word_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .flush      (flush),
        .out_word   (out_word),
        .out_ch     (out_ch),
        .out_cnt    (out_cnt),
        .out_valid  (out_valid),
        .busy       (busy),
        .flush_done (flush_done)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0]  q [4][$];   // bytes held per channel, oldest first
    bit          m_live = 0;
    bit          m_fl = 0;   // flush sequence in progress
    int          m_fp = 0;   // channel the flush visits next
    int          m_n = 0;    // cycles since reset release
    bit          e_valid = 0;
    logic [31:0] e_word = '0;
    logic [1:0]  e_ch = '0;
    logic [2:0]  e_cnt = '0;
    int          m_src;
    bit          m_was, m_stalled;

    task automatic m_emit(input int c);
        e_word = '0;
        for (int i = 0; i < q[c].size(); i++) e_word[i*8 +: 8] = q[c][i];
        e_cnt   = 3'(q[c].size());
        e_ch    = 2'(c);
        e_valid = 1;
        q[c].delete();
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++) q[c].delete();
            m_fl = 0; m_fp = 0; m_n = 0;
            e_valid = 0; e_word = '0; e_ch = '0; e_cnt = '0;
            m_live = 1;
        end else if (m_live) begin
            m_src = (m_n + 3) % 4;
            m_was = m_fl;
            m_stalled = 0;
            e_valid = 0;
            if (din_valid) q[m_src].push_back(din);
            if (din_valid && q[m_src].size() == 4 && !(m_was && m_src == m_fp)) begin
                m_emit(m_src);
                m_stalled = m_was;
            end
            if (m_was) begin
                if (!m_stalled) begin
                    if (q[m_fp].size() != 0) m_emit(m_fp);
                    if (m_fp == 3) m_fl = 0;
                    else m_fp++;
                end
            end else if (flush) begin
                m_fl = 1;
                m_fp = 0;
            end
            m_n++;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    int  c_src;
    bit  c_stall, c_fd;
    always @(negedge clk) begin
        if (m_live) begin
            c_src   = (m_n + 3) % 4;
            c_stall = din_valid && q[c_src].size() == 3 && c_src != m_fp;
            c_fd    = rst_n && m_fl && m_fp == 3 && !c_stall;
            chk("cmp_valid", 32'(out_valid), 32'(e_valid));
            chk("cmp_word", out_word, e_word);
            chk("cmp_ch", 32'(out_ch), 32'(e_ch));
            chk("cmp_cnt", 32'(out_cnt), 32'(e_cnt));
            chk("cmp_busy", 32'(busy), 32'(m_fl));
            chk("cmp_flush_done", 32'(flush_done), 32'(c_fd));
        end
    end

    // ---------------- stimulus ----------------
    // Drive one cycle's inputs, let the edge pass, then return to idle inputs.
    task automatic cyc(input bit r, input bit dv, input logic [7:0] d, input bit fl);
        rst_n = r; din_valid = dv; din = d; flush = fl;
        @(posedge clk);
        #1;
        rst_n = 1'b1; din_valid = 1'b0; din = '0; flush = 1'b0;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic empty_flush(input bit second);
        int nb, nf, nv;
        do_reset();
        cyc(1, 0, 8'h00, 0);                 // cycle 0
        cyc(1, 0, 8'h00, 1);                 // cycle 1: flush
        nb = 0; nf = 0; nv = 0;
        for (int k = 0; k < 8; k++) begin    // cycles 2..9
            if (busy) nb++;
            if (flush_done) nf++;
            if (out_valid) nv++;
            cyc(1, 0, 8'h00, second && k == 1);
        end
        chk(second ? "dflush_busy_cycles" : "eflush_busy_cycles", 32'(nb), 32'd4);
        chk(second ? "dflush_done_pulses" : "eflush_done_pulses", 32'(nf), 32'd1);
        chk(second ? "dflush_out_valid"   : "eflush_out_valid",   32'(nv), 32'd0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Test 1: four channel-A bytes
        do_reset();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_word", out_word, 32'd0);
        chk("rst_ch", 32'(out_ch), 32'd0);
        chk("rst_cnt", 32'(out_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fd", 32'(flush_done), 32'd0);
        for (int n = 0; n <= 13; n++)
            cyc(1, n % 4 == 1, 8'((n / 4 + 1) * 8'h11), 0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_word", out_word, 32'h44332211);
        chk("t1_ch", 32'(out_ch), 32'd0);
        chk("t1_cnt", 32'(out_cnt), 32'd4);

        // Test 2: partial words on B and C drained by flush
        do_reset();
        cyc(1, 0, 8'h00, 0);                 // 0
        cyc(1, 0, 8'h00, 0);                 // 1
        cyc(1, 1, 8'hA1, 0);                 // 2 -> B
        cyc(1, 1, 8'hB1, 0);                 // 3 -> C
        cyc(1, 0, 8'h00, 1);                 // 4 flush
        chk("t2_busy5", 32'(busy), 32'd1);
        cyc(1, 0, 8'h00, 0);                 // 5
        cyc(1, 0, 8'h00, 0);                 // 6
        chk("t2_valid7", 32'(out_valid), 32'd1);
        chk("t2_ch7", 32'(out_ch), 32'd1);
        chk("t2_word7", out_word, 32'h000000A1);
        chk("t2_cnt7", 32'(out_cnt), 32'd1);
        cyc(1, 0, 8'h00, 0);                 // 7
        chk("t2_ch8", 32'(out_ch), 32'd2);
        chk("t2_word8", out_word, 32'h000000B1);
        chk("t2_fd8", 32'(flush_done), 32'd1);
        chk("t2_busy8", 32'(busy), 32'd1);
        cyc(1, 0, 8'h00, 0);                 // 8
        chk("t2_busy9", 32'(busy), 32'd0);
        chk("t2_fd9", 32'(flush_done), 32'd0);
        chk("t2_valid9", 32'(out_valid), 32'd0);

        // Test 3 / 6: empty flush, then a second flush pulse while busy
        empty_flush(1'b0);
        empty_flush(1'b1);

        // Test 4: D completes a word while the flush visits C
        do_reset();
        for (int n = 0; n <= 12; n++) begin
            if (n == 0 || n == 4 || n == 8 || n == 12)
                cyc(1, 1, 8'(8'hD1 + n / 4), 0);
            else if (n == 3)
                cyc(1, 1, 8'hC1, 0);
            else
                cyc(1, 0, 8'h00, n == 9);
        end
        chk("t4_valid13", 32'(out_valid), 32'd1);
        chk("t4_ch13", 32'(out_ch), 32'd3);
        chk("t4_word13", out_word, 32'hD4D3D2D1);
        chk("t4_cnt13", 32'(out_cnt), 32'd4);
        cyc(1, 0, 8'h00, 0);                 // 13
        chk("t4_ch14", 32'(out_ch), 32'd2);
        chk("t4_word14", out_word, 32'h000000C1);
        chk("t4_cnt14", 32'(out_cnt), 32'd1);
        chk("t4_fd14", 32'(flush_done), 32'd1);
        cyc(1, 0, 8'h00, 0);                 // 14
        chk("t4_busy15", 32'(busy), 32'd0);

        // Test 5: reset while A holds three bytes (outputs still show C word)
        for (int n = 15; n <= 25; n++)
            cyc(1, n % 4 == 1, 8'hE0 + 8'(n), 0);
        cyc(0, 0, 8'h00, 0);                 // reset cycle
        chk("t5_valid", 32'(out_valid), 32'd0);
        chk("t5_word", out_word, 32'd0);
        chk("t5_ch", 32'(out_ch), 32'd0);
        chk("t5_cnt", 32'(out_cnt), 32'd0);
        for (int n = 0; n <= 13; n++)
            cyc(1, n % 4 == 1, 8'(8'h51 + n / 4), 0);
        chk("t5_word_new", out_word, 32'h54535251);
        chk("t5_cnt_new", 32'(out_cnt), 32'd4);
        chk("t5_valid_new", 32'(out_valid), 32'd1);

        // Random phase, checked every cycle by the model comparator
        for (int i = 0; i < 3000; i++) begin
            bit r, dv, fl;
            r  = ($urandom_range(0, 199) != 0);
            dv = ($urandom_range(0, 9) < 6);
            fl = ($urandom_range(0, 19) == 0);
            cyc(r, dv, 8'($urandom), fl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
